// File: rtl/decoder_3x8_stream.sv
// Streaming 3-to-8 decoder: codes arrive over valid/ready, queue in a small FIFO,
// and are replayed as timed one-hot strobes separated by an idle gap.
module decoder_3x8_stream #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    y_reg;
  logic [7:0]    next_word;
  logic          fifo_empty, push, pop;

  assign fifo_empty = (count == '0);
  assign in_ready   = rst_n & (count != FULL_CNT);
  assign push       = in_valid & in_ready;
  // Pop only on the edges where the FSM actually loads a new word.
  assign pop        = en & ~fifo_empty &
                      ((state == IDLE) | ((state == GAP) & (cnt == '0)));

  assign y    = y_reg & {8{en}};
  assign busy = (state != IDLE) | ~fifo_empty;

  always_comb begin
    next_word = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mem[rd_ptr] == 3'(i)) next_word[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      y_reg <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= DRIVE;
            y_reg <= next_word;
            cnt   <= HOLD_LOAD;
          end
        end
        DRIVE: begin
          if (en) begin
            if (cnt == '0) begin
              state <= GAP;
              y_reg <= '0;
              cnt   <= GAP_LOAD;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        GAP: begin
          if (en) begin
            if (cnt == '0) begin
              if (pop) begin
                state <= DRIVE;
                y_reg <= next_word;
                cnt   <= HOLD_LOAD;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
